pc_next_unit: RTL and testbench
===============================

# pc_next_unit

Program-counter register and next-PC selection for the single-cycle MIPS datapath. Consumes the 28-bit word-aligned jump field produced by the jump-address left-shifter, the shifted branch offset and the register-jump target. From these it selects and registers the next PC. Also emits a one-cycle redirect flush, an address-error pulse and an EPC capture for misaligned register jumps, plus a retired-fetch counter.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (word aligned)
- EXC_VECTOR, 32'h0000_0080, PC value loaded on misaligned `jr` target

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold PC and all state this cycle
- jump  in  1  `j`/`jal` decoded
- jump_field  in  28  shifted jump address ({instr[25:0],2'b00})
- branch  in  1  conditional branch decoded
- branch_taken  in  1  branch condition true (ALU zero / compare)
- branch_offset  in  32  sign-extended immediate already shifted left 2
- jr  in  1  `jr`/`jalr` decoded
- jr_target  in  32  register value for `jr`
- pc  out  32  current PC (registered)
- pc_plus4  out  32  pc + 4, combinational
- flush  out  1  registered; 1 for the cycle after a non-sequential PC load
- addr_error  out  1  registered; 1-cycle pulse after misaligned `jr`
- epc  out  32  PC of the faulting `jr` (registered, holds until next fault/reset)
- fetch_count  out  32  count of PC advances (registered)

## Operation
- pc_plus4 = pc + 32'd4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- jump target = {pc_plus4[31:28], jump_field}.
- branch target = pc_plus4 + branch_offset, modulo 2^32, no overflow detection.
- Next-PC priority, highest first:
  1. jr with jr_target[1:0] != 0 -> EXC_VECTOR; epc <= pc; addr_error <= 1.
  2. jr, aligned -> jr_target.
  3. jump -> jump target.
  4. branch && branch_taken -> branch target.
  5. otherwise -> pc_plus4.
- branch without branch_taken is sequential. Simultaneous jr/jump/branch resolves strictly by the priority above.
- flush <= 1 on any edge where cases 1-4 load the PC; otherwise flush <= 0.
- addr_error <= 1 only for case 1, else 0. epc updates only in case 1.
- fetch_count increments by 1 (wrapping at 2^32) on every non-stalled, non-reset edge, regardless of redirect.
- stall = 1: pc, epc and fetch_count hold; flush and addr_error are driven 0. Redirect inputs are ignored. The controller keeps jump/branch/jr asserted until stall drops. pc_plus4 still tracks the held pc.

## Timing
- Reset (sync, priority over stall): pc = RESET_VECTOR, flush = 0, addr_error = 0, epc = 0, fetch_count = 0. pc_plus4 = RESET_VECTOR + 4 combinationally.
- Reset asserted mid-redirect or mid-stall discards the pending selection. The first post-reset edge without reset advances to RESET_VECTOR + 4.
- Next-PC is combinational from inputs and pc. New PC is visible 1 cycle after the selecting edge (latency 1).
- flush/addr_error are asserted during the cycle whose pc equals the redirect target, and last exactly 1 cycle unless the next cycle redirects again.
- Back-to-back redirects: each loads normally; flush stays 1 across consecutive redirect cycles.
- No combinational path from inputs to pc, flush, addr_error, epc or fetch_count.

## Test plan
- Reset then 3 free cycles -> pc = 0x0, 0x4, 0x8, 0xC; flush = 0; fetch_count = 3.
- pc = 0x1000_0010, jump = 1, jump_field = 0x000_0040 -> next pc = 0x1000_0040, flush = 1 for one cycle, then 0.
- pc = 0x0000_0100, branch = 1, branch_taken = 1, branch_offset = 0xFFFF_FFF0 -> pc = 0x0000_00F4. Same with branch_taken = 0 -> pc = 0x0000_0104, flush = 0.
- jr = 1, jump = 1, branch/taken = 1, jr_target = 0x0000_2000 -> pc = 0x0000_2000. jr_target = 0x0000_2002 at pc = 0x0000_0040 -> pc = EXC_VECTOR, epc = 0x0000_0040, addr_error pulse 1 cycle.
- stall = 1 for 4 cycles with jump asserted -> pc, fetch_count unchanged, flush = 0. Stall drops -> jump taken next edge.
- pc = 0xFFFF_FFFC sequential -> pc = 0x0000_0000. Reset asserted together with stall and jr -> pc = RESET_VECTOR, all outputs at reset values.

Source files
------------

// File: rtl/pc_next_unit.sv
// pc_next_unit
// Program-counter register and next-PC selection for the single-cycle MIPS
// datapath. Picks the next PC from the register-jump target, the jump field,
// the branch target or the sequential address, and registers it. Also
// produces a redirect flush, a misaligned-jr address-error pulse with EPC
// capture, and a count of retired fetches.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset (priority over stall)
//   stall          hold pc, epc, fetch_count; flush/addr_error forced low
//   jump           j/jal decoded
//   jump_field     {instr[25:0], 2'b00}
//   branch         conditional branch decoded
//   branch_taken   branch condition true
//   branch_offset  sign-extended immediate, already shifted left 2
//   jr             jr/jalr decoded
//   jr_target      register value for jr
//   pc             current PC (registered)
//   pc_plus4       pc + 4 (combinational)
//   flush          1 for the cycle after a non-sequential PC load
//   addr_error     1-cycle pulse after a misaligned jr
//   epc            PC of the last faulting jr
//   fetch_count    number of non-stalled, non-reset edges (wraps)
module pc_next_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump,
  input  logic [27:0] jump_field,
  input  logic        branch,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        addr_error,
  output logic [31:0] epc,
  output logic [31:0] fetch_count
);

  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] next_pc;
  logic        redirect;
  logic        jr_misaligned;

  assign pc_plus4      = pc + 32'd4;
  assign jump_target   = {pc_plus4[31:28], jump_field};
  assign branch_target = pc_plus4 + branch_offset;
  assign jr_misaligned = jr && (jr_target[1:0] != 2'b00);

  // Priority: misaligned jr, jr, jump, taken branch, sequential.
  always_comb begin
    next_pc  = pc_plus4;
    redirect = 1'b1;
    if (jr_misaligned) begin
      next_pc = EXC_VECTOR;
    end else if (jr) begin
      next_pc = jr_target;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (branch && branch_taken) begin
      next_pc = branch_target;
    end else begin
      redirect = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_VECTOR;
      flush       <= 1'b0;
      addr_error  <= 1'b0;
      epc         <= 32'd0;
      fetch_count <= 32'd0;
    end else if (stall) begin
      // Redirect inputs stay asserted by the controller and are taken once
      // the stall drops, so nothing is latched here.
      flush      <= 1'b0;
      addr_error <= 1'b0;
    end else begin
      pc          <= next_pc;
      flush       <= redirect;
      addr_error  <= jr_misaligned;
      fetch_count <= fetch_count + 32'd1;
      if (jr_misaligned) begin
        epc <= pc;
      end
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        jump;
  logic [27:0] jump_field;
  logic        branch;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        flush;
  logic        addr_error;
  logic [31:0] epc;
  logic [31:0] fetch_count;

  int          n_vec;
  int          n_bad;
  logic [31:0] exp_fc;

  pc_next_unit #(
    .RESET_VECTOR(32'h0000_0000),
    .EXC_VECTOR  (32'h0000_0080)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .jump         (jump),
    .jump_field   (jump_field),
    .branch       (branch),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jr           (jr),
    .jr_target    (jr_target),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .flush        (flush),
    .addr_error   (addr_error),
    .epc          (epc),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; expected fetch count follows the inputs applied to it.
  task automatic step();
    if (reset)       exp_fc = 32'd0;
    else if (!stall) exp_fc = exp_fc + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic clear_ctl();
    stall = 0; jump = 0; branch = 0; branch_taken = 0; jr = 0;
  endtask

  // Load an aligned PC through a jr redirect.
  task automatic load_pc(input logic [31:0] v);
    clear_ctl();
    jr = 1; jr_target = v;
    step();
    check("load_pc", pc, v);
    jr = 0;
  endtask

  initial begin
    n_vec = 0; n_bad = 0; exp_fc = 0;
    reset = 1; clear_ctl();
    jump_field = '0; branch_offset = '0; jr_target = '0;
    #1;
    step(); step();
    check("rst_pc", pc, 32'h0);
    check("rst_pc4", pc_plus4, 32'h4);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_aerr", {31'd0, addr_error}, 32'd0);
    check("rst_epc", epc, 32'h0);
    check("rst_fc", fetch_count, 32'd0);

    reset = 0;
    step(); check("seq1", pc, 32'h4);
    step(); check("seq2", pc, 32'h8);
    step(); check("seq3", pc, 32'hC);
    check("seq_flush", {31'd0, flush}, 32'd0);
    check("seq_fc", fetch_count, 32'd3);

    // Jump: 0x1000_0010 -> {0x1, 0x0000040}
    load_pc(32'h1000_0010);
    check("jr_flush", {31'd0, flush}, 32'd1);
    jump = 1; jump_field = 28'h000_0040;
    step();
    check("jump_pc", pc, 32'h1000_0040);
    check("jump_flush_b2b", {31'd0, flush}, 32'd1);
    jump = 0;
    step();
    check("after_jump_pc", pc, 32'h1000_0044);
    check("after_jump_flush", {31'd0, flush}, 32'd0);

    // Branch taken backwards and not taken.
    load_pc(32'h0000_0100);
    branch = 1; branch_taken = 1; branch_offset = 32'hFFFF_FFF0;
    step();
    check("br_taken_pc", pc, 32'h0000_00F4);
    check("br_taken_flush", {31'd0, flush}, 32'd1);
    load_pc(32'h0000_0100);
    branch = 1; branch_taken = 0;
    step();
    check("br_nt_pc", pc, 32'h0000_0104);
    check("br_nt_flush", {31'd0, flush}, 32'd0);
    branch = 0;

    // Priority: jr over jump over branch.
    jr = 1; jump = 1; branch = 1; branch_taken = 1;
    jr_target = 32'h0000_2000; jump_field = 28'h000_0500; branch_offset = 32'h40;
    step();
    check("prio_jr", pc, 32'h0000_2000);
    jr = 0;
    step();
    check("prio_jump", pc, 32'h0000_0500);
    clear_ctl();

    // Misaligned jr.
    load_pc(32'h0000_0040);
    jr = 1; jr_target = 32'h0000_2002;
    step();
    check("exc_pc", pc, 32'h0000_0080);
    check("exc_epc", epc, 32'h0000_0040);
    check("exc_aerr", {31'd0, addr_error}, 32'd1);
    check("exc_flush", {31'd0, flush}, 32'd1);
    jr = 0;
    step();
    check("exc_pc_next", pc, 32'h0000_0084);
    check("exc_aerr_drop", {31'd0, addr_error}, 32'd0);
    check("exc_epc_hold", epc, 32'h0000_0040);
    check("exc_fc", fetch_count, exp_fc);

    // Stall with jump pending.
    stall = 1; jump = 1; jump_field = 28'h000_0100;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_pc", pc, 32'h0000_0084);
      check("stall_flush", {31'd0, flush}, 32'd0);
      check("stall_pc4", pc_plus4, 32'h0000_0088);
    end
    check("stall_fc", fetch_count, exp_fc);
    stall = 0;
    step();
    check("unstall_jump", pc, 32'h0000_0100);
    check("unstall_flush", {31'd0, flush}, 32'd1);
    check("unstall_fc", fetch_count, exp_fc);
    jump = 0;

    // Wrap at the top of the address space.
    load_pc(32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4, 32'h0000_0000);
    step();
    check("wrap_pc", pc, 32'h0000_0000);

    // Reset wins over stall and a misaligned jr.
    load_pc(32'h0000_3000);
    reset = 1; stall = 1; jr = 1; jr_target = 32'h0000_0003;
    step();
    check("rst2_pc", pc, 32'h0);
    check("rst2_flush", {31'd0, flush}, 32'd0);
    check("rst2_aerr", {31'd0, addr_error}, 32'd0);
    check("rst2_epc", epc, 32'h0);
    check("rst2_fc", fetch_count, 32'd0);
    reset = 0; clear_ctl();
    step();
    check("post_rst_pc", pc, 32'h4);
    check("post_rst_fc", fetch_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
